// File: rtl/seg7_count_ctrl.sv
`default_nettype none
// ============================================================================
// seg7_count_ctrl : debounced run/clear/step control of a wrapping 4-bit
// counter with a registered a-g segment bus.
// Option macro: SEG7_COMMON_ANODE_EN (active-low segments). Revision: 1.0
// ============================================================================
module seg7_count_ctrl #(
  parameter int unsigned CLK_HZ          = 27000000,
  parameter int unsigned TICK_HZ         = 1,
  parameter int unsigned DEBOUNCE_CYCLES = 270000,
  parameter int unsigned MAX_COUNT       = 9
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_btn_run,
  input  logic       i_btn_clr,
  input  logic       i_btn_step,
  input  logic       i_dir,
  output logic [3:0] o_counter,
  output logic [6:0] o_seg,
  output logic       o_tick,
  output logic       o_running
);

  localparam int unsigned c_DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned c_PW  = $clog2(c_DIV);
  localparam int unsigned c_DBW = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [c_PW-1:0]  c_PRESC_LAST = c_PW'(c_DIV - 1);
  localparam logic [c_DBW-1:0] c_DB_LAST    = c_DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]       c_MAX        = 4'(MAX_COUNT);

  localparam logic [0:0] c_S_RUN   = 1'b0;
  localparam logic [0:0] c_S_PAUSE = 1'b1;

`ifdef SEG7_COMMON_ANODE_EN
  localparam logic [6:0] c_SEG_RST = 7'b0000001;
`else
  localparam logic [6:0] c_SEG_RST = 7'b1111110;
`endif

  logic [2:0] w_raw;
  logic [2:0] w_ev;
  logic       w_ev_run;
  logic       w_ev_clr;
  logic       w_ev_step;

  assign w_raw     = {i_btn_step, i_btn_clr, i_btn_run};
  assign w_ev_run  = w_ev[0];
  assign w_ev_clr  = w_ev[1];
  assign w_ev_step = w_ev[2];

  // Per button: 2-flop sync, debounce to an accepted level, rising-edge event.
  for (genvar gi = 0; gi < 3; gi++) begin : g_btn
    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_d;
    logic             level_dly_q;
    logic             ev_q;
    logic [c_DBW-1:0] db_cnt_q;
    logic [c_DBW-1:0] db_cnt_d;

    always_comb begin
      level_d  = level_q;
      db_cnt_d = '0;
      if (sync2_q != level_q) begin
        if (db_cnt_q == c_DB_LAST) begin
          level_d = sync2_q;
        end else begin
          db_cnt_d = db_cnt_q + c_DBW'(1);
        end
      end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        sync1_q     <= 1'b0;
        sync2_q     <= 1'b0;
        level_q     <= 1'b0;
        level_dly_q <= 1'b0;
        ev_q        <= 1'b0;
        db_cnt_q    <= '0;
      end else begin
        sync1_q     <= w_raw[gi];
        sync2_q     <= sync1_q;
        level_q     <= level_d;
        level_dly_q <= level_q;
        ev_q        <= level_q & ~level_dly_q;
        db_cnt_q    <= db_cnt_d;
      end
    end

    assign w_ev[gi] = ev_q;
  end

  logic [0:0] state_q;
  logic [0:0] state_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= c_S_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (w_ev_run) begin
      state_d = (state_q == c_S_RUN) ? c_S_PAUSE : c_S_RUN;
    end
  end

  always_comb begin
    o_running = (state_q == c_S_RUN);
  end

  logic [c_PW-1:0] presc_q;
  logic [c_PW-1:0] presc_d;
  logic            w_presc_last;
  logic            w_advance;

  assign w_presc_last = (presc_q == c_PRESC_LAST);

  // Zeroing on entry to RUN makes the first advance land a full period later.
  always_comb begin
    presc_d = presc_q + c_PW'(1);
    if (w_ev_clr || (state_q != c_S_RUN) || (state_d != c_S_RUN) || w_presc_last) begin
      presc_d = '0;
    end
  end

  always_comb begin
    w_advance = (state_q == c_S_RUN) ? w_presc_last : (w_ev_step & ~w_ev_run);
  end

  logic [3:0] counter_q;
  logic [3:0] counter_d;
  logic       tick_q;
  logic       tick_d;
  logic [6:0] seg_q;
  logic [6:0] seg_d;

  always_comb begin
    counter_d = counter_q;
    tick_d    = 1'b0;
    if (w_ev_clr) begin
      counter_d = 4'd0;
    end else if (w_advance) begin
      tick_d = 1'b1;
      if (i_dir) begin
        counter_d = (counter_q == 4'd0) ? c_MAX : counter_q - 4'd1;
      end else begin
        counter_d = (counter_q >= c_MAX) ? 4'd0 : counter_q + 4'd1;
      end
    end
  end

  function automatic logic [6:0] f_glyph(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'h0:    g = 7'b1111110;
      4'h1:    g = 7'b0110000;
      4'h2:    g = 7'b1101101;
      4'h3:    g = 7'b1111001;
      4'h4:    g = 7'b0110011;
      4'h5:    g = 7'b1011011;
      4'h6:    g = 7'b1011111;
      4'h7:    g = 7'b1110000;
      4'h8:    g = 7'b1111111;
      4'h9:    g = 7'b1111011;
      4'hA:    g = 7'b1110111;
      4'hB:    g = 7'b0011111;
      4'hC:    g = 7'b1001110;
      4'hD:    g = 7'b0111101;
      4'hE:    g = 7'b1001111;
      default: g = 7'b1000111;
    endcase
    return g;
  endfunction

  always_comb begin
`ifdef SEG7_COMMON_ANODE_EN
    seg_d = ~f_glyph(counter_q);
`else
    seg_d = f_glyph(counter_q);
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      presc_q   <= '0;
      counter_q <= 4'd0;
      tick_q    <= 1'b0;
      seg_q     <= c_SEG_RST;
    end else begin
      presc_q   <= presc_d;
      counter_q <= counter_d;
      tick_q    <= tick_d;
      seg_q     <= seg_d;
    end
  end

  assign o_counter = counter_q;
  assign o_tick    = tick_q;
  assign o_seg     = seg_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_count_ctrl.sv
`default_nettype none
// ============================================================================
// tb_seg7_count_ctrl : randomized bench with a cycle-indexed reference model
// and a tick scoreboard. Revision: 1.0
// ============================================================================
module tb_seg7_count_ctrl;

  localparam int D    = 4;
  localparam int DIV  = 8;
  localparam int MAXC = 9;
  localparam int LAT  = D + 3;

  localparam logic [6:0] GLYPH [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_run = 1'b0;
  logic       btn_clr = 1'b0;
  logic       btn_step = 1'b0;
  logic       dir = 1'b0;
  logic [3:0] counter;
  logic [6:0] seg;
  logic       tick;
  logic       running;

  always #5 clk = ~clk;

  seg7_count_ctrl #(
    .CLK_HZ         (8),
    .TICK_HZ        (1),
    .DEBOUNCE_CYCLES(D),
    .MAX_COUNT      (MAXC)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_btn_run (btn_run),
    .i_btn_clr (btn_clr),
    .i_btn_step(btn_step),
    .i_dir     (dir),
    .o_counter (counter),
    .o_seg     (seg),
    .o_tick    (tick),
    .o_running (running)
  );

  typedef struct {
    int c;
    int v;
  } tick_t;

  tick_t tq[$];
  int    exp_cnt[int];
  int    exp_run[int];
  int    ev_at[int];

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;

  int m_cnt;
  int m_anchor;
  bit m_run;

  int hi_left[3];
  bit first[3];
  int lo_run[3];
  bit raw[3];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic logic [6:0] glyph(input int v);
`ifdef SEG7_COMMON_ANODE_EN
    return ~GLYPH[v];
`else
    return GLYPH[v];
`endif
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, req);
    end
  endtask

  // Monitor: per-cycle state comparison plus tick scoreboard.
  always @(negedge clk) begin
    if (mon_en && rst_n && cyc > 0) begin
      chk("counter", int'(counter), exp_cnt.exists(cyc) ? exp_cnt[cyc] : -1);
      chk("running", int'(running), exp_run.exists(cyc) ? exp_run[cyc] : -1);
      chk("seg", int'(seg), exp_cnt.exists(cyc - 1) ? int'(glyph(exp_cnt[cyc - 1])) : -1);
      if (tick) begin
        if (tq.size() == 0) begin
          chk("tick_unexpected", 1, 0);
        end else begin
          tick_t t;
          t = tq.pop_front();
          chk("tick_cycle", cyc, t.c);
          chk("tick_value", int'(counter), t.v);
        end
      end else if (tq.size() > 0 && tq[0].c <= cyc) begin
        tick_t t;
        t = tq.pop_front();
        chk("tick_missing", cyc, t.c);
      end
    end
  end

  // Drives buttons for edge cyc+1, predicts that edge, then waits a cycle.
  task automatic step_cycle();
    int  k;
    int  ev;
    bit  adv;
    k = cyc + 1;
    for (int b = 0; b < 3; b++) begin
      if (hi_left[b] > 0) begin
        raw[b] = 1'b1;
        if (first[b]) begin
          ev_at[k + LAT] = (ev_at.exists(k + LAT) ? ev_at[k + LAT] : 0) | (1 << b);
          first[b] = 1'b0;
        end
        hi_left[b]--;
        lo_run[b] = 0;
      end else begin
        raw[b] = 1'b0;
        lo_run[b]++;
      end
    end
    btn_run  = raw[0];
    btn_clr  = raw[1];
    btn_step = raw[2];

    ev = ev_at.exists(k) ? ev_at[k] : 0;
    if (m_run) adv = (((k - m_anchor) % DIV) == 0);
    else       adv = ev[2] && !ev[0];
    if (ev[1]) adv = 1'b0;
    if (adv) begin
      if (dir) m_cnt = (m_cnt == 0) ? MAXC : m_cnt - 1;
      else     m_cnt = (m_cnt == MAXC) ? 0 : m_cnt + 1;
      tq.push_back('{k, m_cnt});
    end
    if (ev[1]) begin
      m_cnt    = 0;
      m_anchor = k;
    end
    if (ev[0]) begin
      m_run = !m_run;
      if (m_run) m_anchor = k;
    end
    exp_cnt[k] = m_cnt;
    exp_run[k] = m_run ? 1 : 0;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step_cycle();
  endtask

  function automatic bit idle(input int b);
    return (hi_left[b] == 0) && (lo_run[b] >= D + 2);
  endfunction

  task automatic pulse(input int b, input int w, input bit real_press);
    while (!idle(b)) step_cycle();
    hi_left[b] = w;
    first[b]   = real_press;
  endtask

  task automatic apply_reset_and_release();
    mon_en   = 1'b0;
    rst_n    = 1'b0;
    btn_run  = 1'b0;
    btn_clr  = 1'b0;
    btn_step = 1'b0;
    for (int b = 0; b < 3; b++) begin
      hi_left[b] = 0;
      first[b]   = 1'b0;
      lo_run[b]  = D + 2;
      raw[b]     = 1'b0;
    end
    tq.delete();
    exp_cnt.delete();
    exp_run.delete();
    ev_at.delete();
    m_cnt    = 0;
    m_run    = 1'b1;
    m_anchor = 0;
    exp_cnt[0] = 0;
    exp_run[0] = 1;
    repeat (3) @(negedge clk);
    chk("rst_counter", int'(counter), 0);
    chk("rst_seg", int'(seg), int'(glyph(0)));
    chk("rst_tick", int'(tick), 0);
    chk("rst_running", int'(running), 1);
    rst_n  = 1'b1;
    mon_en = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    int kc;
    apply_reset_and_release();

    // Free-running count up with wrap.
    dir = 1'b0;
    run(72);
    chk("up_at_72", int'(counter), 9);
    run(1);
    chk("seg_of_9", int'(seg), int'(glyph(9)));
    run(7);
    chk("wrap_to_0", int'(counter), 0);
    chk("wrap_tick", int'(tick), 1);

    // Count down from 0 wraps to MAX.
    dir = 1'b1;
    run(8);
    chk("down_wrap", int'(counter), 9);
    run(1);
    chk("down_seg", int'(seg), int'(glyph(9)));

    // Pause, frozen count, single steps.
    pulse(0, 10, 1'b1);
    run(LAT);
    chk("still_running", int'(running), 1);
    run(1);
    chk("paused", int'(running), 0);
    base = m_cnt;
    run(100);
    chk("frozen", int'(counter), base);
    dir = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pulse(2, 6, 1'b1);
      run(LAT + 4);
    end
    chk("three_steps", int'(counter), (base + 3) % (MAXC + 1));
    pulse(0, 6, 1'b1);
    run(LAT + 1);
    chk("resumed", int'(running), 1);

    // Short bounces on run must be ignored.
    for (int i = 0; i < 4; i++) pulse(0, 3, 1'b0);
    run(20);
    chk("bounce_ignored", int'(running), 1);

    // Clear landing on a scheduled advance.
    dir = 1'b0;
    while (!idle(1) || (((cyc + 1 + LAT - m_anchor) % DIV) != 0)) step_cycle();
    kc = cyc + 1 + LAT;
    pulse(1, 6, 1'b1);
    while (cyc < kc) step_cycle();
    chk("clr_count", int'(counter), 0);
    chk("clr_no_tick", int'(tick), 0);
    while (cyc < kc + DIV) step_cycle();
    chk("after_clr_count", int'(counter), 1);
    chk("after_clr_tick", int'(tick), 1);

    // Randomized presses, bounces and direction changes.
    for (int i = 0; i < 1500; i++) begin
      int r;
      int b;
      if ($urandom_range(0, 29) == 0) dir = ~dir;
      r = $urandom_range(0, 99);
      b = $urandom_range(0, 2);
      if (r < 4 && idle(b)) begin
        hi_left[b] = $urandom_range(D, D + 6);
        first[b]   = 1'b1;
      end else if (r < 6 && idle(b)) begin
        hi_left[b] = $urandom_range(1, D - 1);
        first[b]   = 1'b0;
      end
      step_cycle();
    end
    run(LAT + 2);
    #1;
    chk("queue_drained", tq.size(), 0);

    // Asynchronous reset in the middle of counting.
    apply_reset_and_release();
    dir = 1'b0;
    run(51);
    chk("pre_reset_count", int'(counter), 6);
    mon_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_counter", int'(counter), 0);
    chk("async_seg", int'(seg), int'(glyph(0)));
    chk("async_running", int'(running), 1);
    chk("async_tick", int'(tick), 0);
    @(negedge clk);
    apply_reset_and_release();
    run(DIV + 4);
    chk("post_reset_count", int'(counter), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seg7_count_ctrl.md
# seg7_count_ctrl

Sequencing controller for the single-digit 7-segment counter datapath. Generates the count tick from the board clock, debounces run/pause, clear and step buttons, and steps a 4-bit counter up or down with wrap. Drives a registered a–g segment pattern, giving the display and on-chip logic analyser a glitch-free, clock-aligned bus.

## Interface
- CLK_HZ, 27000000, input clock frequency
- TICK_HZ, 1, count rate; DIV = CLK_HZ/TICK_HZ, which must be ≥ 2
- DEBOUNCE_CYCLES, 270000, stable cycles required before a button level is accepted (≥ 1)
- MAX_COUNT, 9, last counter value before wrap (1..15)

- i_clk  in  1  system clock
- i_rst_n  in  1  reset, asynchronous and active-low
- i_btn_run  in  1  raw button, active-high; each press toggles run/pause
- i_btn_clr  in  1  raw button, active-high; a press clears the count
- i_btn_step  in  1  raw button, active-high; a press advances one count while paused
- i_dir  in  1  0 = count up, 1 = count down; sampled on each advance
- o_counter  out  4  current count
- o_seg  out  7  {a,b,c,d,e,f,g}, registered
- o_tick  out  1  one-cycle pulse on every counter advance
- o_running  out  1  high in S_RUN

## Operation
- Reset values:
  - o_counter = 0
  - o_seg = pattern for 0 (1111110)
  - o_tick = 0
  - o_running = 1
  - State is S_RUN.
  - Prescaler, debounce counters and synchronisers are 0.
- Button conditioning, per button:
  - The raw input passes through a 2-flop synchroniser.
  - The debounce counter resets on any change of the synchronised level versus the accepted level.
  - After DEBOUNCE_CYCLES consecutive differing cycles, the accepted level takes the new value.
  - A 0→1 transition of the accepted level produces a one-cycle event: ev_run, ev_clr or ev_step.
- FSM:
  - S_RUN → S_PAUSE on ev_run.
  - S_PAUSE → S_RUN on ev_run.
  - No other transitions.
- Prescaler:
  - In S_RUN it counts 0..DIV-1 and wraps.
  - Advance condition in S_RUN: prescaler == DIV-1.
  - In S_PAUSE the prescaler is held at 0. Advance condition in S_PAUSE: ev_step.
  - ev_step in S_RUN is ignored.
- Advance:
  - Up: MAX_COUNT → 0, otherwise +1.
  - Down: 0 → MAX_COUNT, otherwise −1.
  - 4-bit arithmetic, never exceeds MAX_COUNT.
  - o_tick = 1 in the cycle following the advance, coincident with the new o_counter.
- Clear (ev_clr):
  - o_counter ← 0 and prescaler ← 0.
  - FSM state is unchanged.
  - Clear has priority over an advance in the same cycle; no o_tick is issued.
- Simultaneous ev_run and ev_clr: both take effect, i.e. state toggles and count clears.
- Simultaneous ev_run and ev_step in S_PAUSE: the FSM moves to S_RUN and the step is discarded.
- Segment decode: hex glyphs registered from o_counter.
  - 0 = 1111110
  - 1 = 0110000
  - 2 = 1101101
  - 3 = 1111001
  - 4 = 0110011
  - 5 = 1011011
  - 6 = 1011111
  - 7 = 1110000
  - 8 = 1111111
  - 9 = 1111011
  - A = 1110111
  - b = 0011111
  - C = 1001110
  - d = 0111101
  - E = 1001111
  - F = 1000111
- Reset assertion mid-count returns all state to the reset values immediately; no tick is generated on release.

## Timing
- Raw button edge to event pulse: 2 synchroniser cycles + DEBOUNCE_CYCLES + 1.
- Event to o_counter / o_running update: 1 cycle.
- o_counter to o_seg: 1 cycle. o_seg always lags o_counter by exactly one cycle.
- In S_RUN, the first advance after reset or clear occurs DIV cycles later; advances then repeat every DIV cycles.
- Bounces shorter than DEBOUNCE_CYCLES produce no event.

## Configuration
- SEG7_COMMON_ANODE_EN:
  - Defined: o_seg is the bitwise inverse of the table above (active-low segments). The reset value is 0000001.
  - Undefined: active-high as tabled.
  - All other behaviour is identical.

## Test plan
All tests use CLK_HZ=8, TICK_HZ=1 (DIV=8), DEBOUNCE_CYCLES=4, MAX_COUNT=9.

- Release reset, i_dir=0, 80 cycles → o_counter steps 1..9 then wraps to 0. o_tick pulses every 8 cycles. o_seg follows one cycle later (9 → 1111011, 0 → 1111110).
- i_dir=1 from count 0 → next advance gives o_counter=9 and o_seg=1111011.
- Press run for 10 cycles → o_running=0 at 2+4+1+1 cycles after the press. The count stays frozen for 100 cycles. Three step presses advance it by exactly 3, each with one o_tick.
- Run button bouncing with 3-cycle pulses → no event; o_running is unchanged.
- Clear event in the same cycle as a scheduled advance → o_counter=0, no o_tick. The next advance comes 8 cycles later, giving 1.
- Assert i_rst_n low mid-count at 6 → o_counter=0, o_seg=1111110, o_running=1 asynchronously. Repeat with SEG7_COMMON_ANODE_EN defined → o_seg=0000001.
